// File: rtl/count_unit_pkg.sv
// Shared types and constants for the count unit: FSM state, counter width and the wrap step.
package count_unit_pkg;

    localparam int unsigned COUNT_W = 4;
    localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(15);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHold
    } state_e;

    typedef struct packed {
        logic [COUNT_W-1:0] count;
        logic               co;
    } step_t;

    // One count tick: increment, or reload from the init value with carry at COUNT_MAX.
    function automatic step_t count_step(input logic [COUNT_W-1:0] cur,
                                         input logic [COUNT_W-1:0] init);
        step_t s;
        if (cur == COUNT_MAX) begin
            s.count = init;
            s.co    = 1'b1;
        end else begin
            s.count = cur + COUNT_W'(1);
            s.co    = 1'b0;
        end
        return s;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and flags the terminal cycle as a tick.
module tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] Last = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == Last) ? '0 : cnt_q + CW'(1);
        end
    end

    assign tick = en & ~clr & (cnt_q == Last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/count_unit.sv
// Prescaled 4-bit up counter with reload-on-wrap, pause/hold and a one-cycle carry pulse.
module count_unit
    import count_unit_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pause,
    input  logic               stop,
    input  logic [COUNT_W-1:0] Din,
    output logic [COUNT_W-1:0] Count_out,
    output logic               Co,
    output logic               running
);

    state_e             state_q;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] init_q;
    logic               co_q;
    logic               running_q;

    logic  tick;
    logic  presc_en;
    logic  presc_clr;
    step_t step;

    // Leaving HOLD with pause low counts on that same edge, so a resume continues seamlessly.
    assign presc_en  = (state_q != StIdle) && !pause;
    assign presc_clr = start | stop;
    assign step      = count_step(count_q, init_q);

    tick_gen #(
        .DIV(DIV)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (presc_en),
        .clr (presc_clr),
        .tick(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            count_q   <= '0;
            init_q    <= '0;
            co_q      <= 1'b0;
            running_q <= 1'b0;
        end else begin
            co_q <= 1'b0;
            if (start) begin
                count_q   <= Din;
                init_q    <= Din;
                state_q   <= pause ? StHold : StRun;
                running_q <= 1'b1;
            end else if (stop) begin
                state_q   <= StIdle;
                running_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q   <= StIdle;
                        running_q <= 1'b0;
                    end
                    StRun, StHold: begin
                        running_q <= 1'b1;
                        if (pause) begin
                            state_q <= StHold;
                        end else begin
                            state_q <= StRun;
                            if (tick) begin
                                count_q <= step.count;
                                co_q    <= step.co;
                            end
                        end
                    end
                    default: begin
                        state_q   <= StIdle;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Count_out = count_q;
    assign Co        = co_q;
    assign running   = running_q;

endmodule

// File: tb/tb_count_unit.sv
// Directed bench for count_unit with DIV = 4 and hand-computed expectations.
module tb_count_unit;

    logic       clk;
    logic       rst;
    logic       start;
    logic       pause;
    logic       stop;
    logic [3:0] Din;
    logic [3:0] Count_out;
    logic       Co;
    logic       running;

    int checks = 0;
    int errors = 0;

    count_unit #(
        .DIV(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pause    (pause),
        .stop     (stop),
        .Din      (Din),
        .Count_out(Count_out),
        .Co       (Co),
        .running  (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] cnt, input logic co,
                             input logic run);
        check({tag, ".count"}, 16'(Count_out), 16'(cnt));
        check({tag, ".co"}, 16'(Co), 16'(co));
        check({tag, ".running"}, 16'(running), 16'(run));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
        Din   = 4'd0;
        step(2);
        check_all("reset", 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step(2);
        check_all("idle_after_reset", 4'd0, 1'b0, 1'b0);

        // Din = 5: first increment 4 edges after start, wrap back to 5 at edge 44.
        Din   = 4'd5;
        start = 1'b1;
        step(1);
        start = 1'b0;
        check_all("load5", 4'd5, 1'b0, 1'b1);
        step(3);
        check_all("before_first_tick", 4'd5, 1'b0, 1'b1);
        step(1);
        check_all("first_tick", 4'd6, 1'b0, 1'b1);
        for (int v = 7; v <= 15; v++) begin
            step(4);
            check("ramp.count", 16'(Count_out), 16'(v));
            check("ramp.co", 16'(Co), 16'd0);
        end
        step(4);
        check_all("wrap", 4'd5, 1'b1, 1'b1);
        step(1);
        check_all("wrap_next", 4'd5, 1'b0, 1'b1);

        // Reach 9, then assert reset between clock edges.
        step(15);
        check_all("at9", 4'd9, 1'b0, 1'b1);
        step(1);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_reset", 4'd0, 1'b0, 1'b0);
        start = 1'b1;
        Din   = 4'd3;
        step(1);
        check_all("start_ignored_in_reset", 4'd0, 1'b0, 1'b0);
        rst   = 1'b0;
        start = 1'b0;
        step(6);
        check_all("idle_after_release", 4'd0, 1'b0, 1'b0);

        // Din = 15: carry every 4 cycles, count pinned at 15.
        Din   = 4'd15;
        start = 1'b1;
        step(1);
        start = 1'b0;
        check_all("load15", 4'd15, 1'b0, 1'b1);
        step(3);
        check_all("d15_pre", 4'd15, 1'b0, 1'b1);
        step(1);
        check_all("d15_co1", 4'd15, 1'b1, 1'b1);
        step(1);
        check_all("d15_co_off", 4'd15, 1'b0, 1'b1);
        step(3);
        check_all("d15_co2", 4'd15, 1'b1, 1'b1);

        // Count 7 with prescaler at 2, paused for 10 cycles.
        Din   = 4'd7;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check_all("paused", 4'd7, 1'b0, 1'b1);
        end
        pause = 1'b0;
        step(1);
        check_all("resume1", 4'd7, 1'b0, 1'b1);
        step(1);
        check_all("resume2", 4'd8, 1'b0, 1'b1);

        // Start with Din = 12 exactly on a wrap tick at 15.
        Din   = 4'd15;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        Din   = 4'd12;
        start = 1'b1;
        step(1);
        start = 1'b0;
        check_all("start_on_tick", 4'd12, 1'b0, 1'b1);

        // Stop on a tick cycle: tick discarded.
        step(3);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check_all("stop_on_tick", 4'd12, 1'b0, 1'b0);
        step(4);
        check_all("idle_hold", 4'd12, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_unit.md
COUNT_UNIT -- requirements
Module: count_unit

Interface
REQ-001 Parameter DIV, default 4, prescaler terminal count: clock cycles per count tick, legal range 2..2^16.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  synchronous pulse; loads Din and enters RUN.
REQ-005 pause  input  1  level; while high in RUN, counting is frozen.
REQ-006 stop  input  1  synchronous pulse; returns to IDLE, holds Count_out.
REQ-007 Din  input  4  initial/reload count value, sampled on start.
REQ-008 Count_out  output  4  current count; feeds the 7-segment decoder directly.
REQ-009 Co  output  1  carry, one-cycle pulse on wrap.
REQ-010 running  output  1  high in RUN and HOLD states.

Function
REQ-011 FSM states: IDLE, RUN, HOLD; encoding is implementation choice.
REQ-012 IDLE -> RUN on start; RUN -> HOLD when pause=1; HOLD -> RUN when pause=0; RUN/HOLD -> IDLE on stop.
REQ-013 Priority per cycle: start > stop > pause > tick.
REQ-014 start in any state: Count_out <= Din, init register <= Din, prescaler cleared, state <= RUN (or HOLD if pause=1).
REQ-015 Prescaler counts 0..DIV-1 only in RUN; tick asserted for one cycle when prescaler = DIV-1, prescaler then returns to 0.
REQ-016 First tick after start occurs exactly DIV cycles after the start edge (with pause=0).
REQ-017 On tick, Count_out < 15: Count_out <= Count_out + 1.
REQ-018 On tick, Count_out = 15: Count_out <= init register value, Co = 1 for that same cycle only.
REQ-019 Din = 15: every tick asserts Co and Count_out stays 15.
REQ-020 HOLD freezes both prescaler and Count_out; resume continues from frozen prescaler value (no restart).
REQ-021 stop: Count_out held, prescaler cleared, Co = 0; tick coincident with stop is discarded.
REQ-022 start coincident with tick: load wins, no increment, no Co.
REQ-023 Co never asserted in IDLE or HOLD.
REQ-024 Count_out arithmetic 4-bit unsigned; no value outside 0..15 reachable.
REQ-025 All outputs registered; Co registered in the same cycle as the Count_out update it accompanies.

Reset
REQ-026 rst high forces immediately, independent of clk: state IDLE, Count_out 0, init register 0, prescaler 0, Co 0, running 0.
REQ-027 rst asserted mid-RUN discards any pending tick; after release block stays in IDLE until start.
REQ-028 Inputs ignored while rst is high; first active edge after release evaluates normally.

Structure
REQ-029 Shared package holds state typedef (IDLE/RUN/HOLD), COUNT_W = 4, COUNT_MAX = 15.
REQ-030 Prescaler is sub-module tick_gen (params DIV; ports clk, rst, en, clr, tick), instantiated once.
REQ-031 No combinational path from any input to any output.

Verification (DIV = 4)
REQ-032 rst pulse mid-count with Count_out = 9 -> Count_out = 0, Co = 0, running = 0 within same cycle, no clk needed.
REQ-033 start with Din = 5, pause = 0 -> Count_out 5, 6 after 4 cycles, ..., 15, then 5 with Co = 1 for one cycle; period 44 cycles.
REQ-034 Din = 15, start -> Co pulses every 4 cycles, Count_out constant 15.
REQ-035 RUN at Count_out = 7, prescaler = 2, pause high 10 cycles -> Count_out 7 throughout, increment to 8 exactly 2 cycles after pause low.
REQ-036 start (Din = 12) on same cycle as tick at Count_out = 15 -> Count_out = 12, Co = 0; stop on a tick cycle -> Count_out unchanged, running = 0.
